mib_table_ctrl: RTL and testbench

- Sits directly downstream of the AHB slave register interface. Serves host register reads and writes that fall in the MIB counter window.
- Backs the window with a single-port synchronous RAM and arbitrates host accesses against MAC-side counter-increment requests, which are done as read-modify-write.
- Produces the mibReady handshake that stalls the AHB data phase, plus registered read data for the upstream read-data mux.

---
 rtl/mib_table_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mib_table_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mib_table_ctrl.sv
// MIB counter window controller: host reads/writes vs MAC increments on one RAM port.
// Ports: hClk/hardRstHClk; host rdWrAddr/regWrData/regWrite/regRead ->
// mibReady/mibSel/mibRdData; MAC mibIncReq/mibIncAddr/mibIncVal -> mibIncAck;
// RAM ramEn/ramWe/ramAddr/ramWData/ramRData.
// Optional MIB_CLEAR_ON_READ_EN: host reads clear the entry (H_CLR state).
module mib_table_ctrl #(
  parameter int unsigned MIB_DEPTH_LOG2 = 7,
  parameter logic [13:0] MIB_BASE_ADDR  = 14'h0800
) (
  input  logic                      hClk,
  input  logic                      hardRstHClk,
  input  logic [13:0]               rdWrAddr,
  input  logic [31:0]               regWrData,
  input  logic                      regWrite,
  input  logic                      regRead,
  output logic                      mibReady,
  output logic                      mibSel,
  output logic [31:0]               mibRdData,
  input  logic                      mibIncReq,
  input  logic [MIB_DEPTH_LOG2-1:0] mibIncAddr,
  input  logic [15:0]               mibIncVal,
  output logic                      mibIncAck,
  output logic                      ramEn,
  output logic                      ramWe,
  output logic [MIB_DEPTH_LOG2-1:0] ramAddr,
  output logic [31:0]               ramWData,
  input  logic [31:0]               ramRData
);

  localparam int unsigned AW = MIB_DEPTH_LOG2;
  localparam logic [14:0] WIN_LO = {1'b0, MIB_BASE_ADDR};
  localparam logic [14:0] WIN_HI = WIN_LO + (15'd1 << AW);

`ifdef MIB_CLEAR_ON_READ_EN
  typedef enum logic [2:0] {
    IDLE, H_RD, H_WAIT, H_WR, I_RD, I_WAIT, I_WR, H_CLR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, H_RD, H_WAIT, H_WR, I_RD, I_WAIT, I_WR
  } state_t;
`endif

  state_t state, nxt;

  logic          in_win, hit;
  logic [AW-1:0] idx;

  logic          pending, pend_wr;
  logic [AW-1:0] pend_addr;
  logic [31:0]   pend_data;

  logic [AW-1:0] inc_addr;
  logic [15:0]   inc_val;
  logic [32:0]   inc_sum;
  logic [31:0]   inc_sat;

  logic          h_req, h_wr, host_go, host_busy;
  logic [AW-1:0] h_addr;
  logic [31:0]   h_data;

  logic          en_d, we_d, ack_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   wdata_d;

  assign in_win = ({1'b0, rdWrAddr} >= WIN_LO) &&
                  ({1'b0, rdWrAddr} <  WIN_HI);
  assign hit    = (regRead | regWrite) & in_win;
  assign idx    = AW'(rdWrAddr - MIB_BASE_ADDR);

  // A latched request (taken during an increment) beats a live strobe.
  assign h_req  = pending | hit;
  assign h_wr   = pending ? pend_wr   : regWrite;
  assign h_addr = pending ? pend_addr : idx;
  assign h_data = pending ? pend_data : regWrData;

  assign inc_sum = {1'b0, ramRData} + {17'd0, inc_val};
  assign inc_sat = inc_sum[32] ? 32'hFFFF_FFFF : inc_sum[31:0];

  always_comb begin
    host_busy = (state == H_RD) || (state == H_WAIT) ||
                (state == H_WR);
`ifdef MIB_CLEAR_ON_READ_EN
    host_busy = host_busy || (state == H_CLR);
`endif
  end

  assign mibReady = !hit & !pending & !host_busy;

  // Next state plus the RAM controls to register for that state.
  always_comb begin
    nxt     = state;
    host_go = 1'b0;
    en_d    = 1'b0;
    we_d    = 1'b0;
    ack_d   = 1'b0;
    addr_d  = ramAddr;
    wdata_d = ramWData;
    case (state)
      IDLE: begin
        if (h_req) begin
          host_go = 1'b1;
        end else if (mibIncReq) begin
          nxt    = I_RD;
          en_d   = 1'b1;
          addr_d = mibIncAddr;
        end
      end
      H_RD:   nxt = H_WAIT;
`ifdef MIB_CLEAR_ON_READ_EN
      H_WAIT: begin
        nxt     = H_CLR;
        en_d    = 1'b1;
        we_d    = 1'b1;
        wdata_d = 32'd0;
      end
      H_CLR:  nxt = IDLE;
`else
      H_WAIT: nxt = IDLE;
`endif
      H_WR:   nxt = IDLE;
      I_RD:   nxt = I_WAIT;
      I_WAIT: begin
        nxt     = I_WR;
        en_d    = 1'b1;
        we_d    = 1'b1;
        ack_d   = 1'b1;
        addr_d  = inc_addr;
        wdata_d = inc_sat;
      end
      I_WR: begin
        if (h_req) host_go = 1'b1;
        else       nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (host_go) begin
      nxt    = h_wr ? H_WR : H_RD;
      en_d   = 1'b1;
      we_d   = h_wr;
      addr_d = h_addr;
      if (h_wr) wdata_d = h_data;
    end
  end

  always_ff @(posedge hClk) begin
    if (hardRstHClk) begin
      state     <= IDLE;
      pending   <= 1'b0;
      pend_wr   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      inc_addr  <= '0;
      inc_val   <= '0;
      mibSel    <= 1'b0;
      mibRdData <= '0;
      mibIncAck <= 1'b0;
      ramEn     <= 1'b0;
      ramWe     <= 1'b0;
      ramAddr   <= '0;
      ramWData  <= '0;
    end else begin
      state     <= nxt;
      mibIncAck <= ack_d;
      ramEn     <= en_d;
      ramWe     <= we_d;
      ramAddr   <= addr_d;
      ramWData  <= wdata_d;
      if (state == I_RD) begin
        inc_addr <= mibIncAddr;
        inc_val  <= mibIncVal;
      end
      if (host_go) begin
        pending <= 1'b0;
      end else if (hit && (state == I_RD || state == I_WAIT)) begin
        pending   <= 1'b1;
        pend_wr   <= regWrite;
        pend_addr <= idx;
        pend_data <= regWrData;
      end
      if (state == H_WAIT) begin
        mibRdData <= ramRData;
        mibSel    <= 1'b1;
      end
      if (hit && regWrite) mibSel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mib_table_ctrl.sv
// Self-checking bench for mib_table_ctrl with a behavioural RAM and
// an entry-array reference model; honours MIB_CLEAR_ON_READ_EN.
module tb_mib_table_ctrl;

`ifdef MIB_CLEAR_ON_READ_EN
  localparam int RD_LAT = 4;
`else
  localparam int RD_LAT = 3;
`endif

  logic        hClk = 0;
  logic        hardRstHClk;
  logic [13:0] rdWrAddr;
  logic [31:0] regWrData;
  logic        regWrite, regRead;
  logic        mibReady, mibSel;
  logic [31:0] mibRdData;
  logic        mibIncReq;
  logic [6:0]  mibIncAddr;
  logic [15:0] mibIncVal;
  logic        mibIncAck;
  logic        ramEn, ramWe;
  logic [6:0]  ramAddr;
  logic [31:0] ramWData, ramRData;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic        we;
    logic [6:0]  a;
    logic [31:0] d;
  } acc_t;
  acc_t acc_q[$];
  int   ack_q[$];

  logic [31:0] ram_mem [128];
  logic [31:0] model   [128];

  mib_table_ctrl dut (
    .hClk(hClk), .hardRstHClk(hardRstHClk),
    .rdWrAddr(rdWrAddr), .regWrData(regWrData),
    .regWrite(regWrite), .regRead(regRead),
    .mibReady(mibReady), .mibSel(mibSel), .mibRdData(mibRdData),
    .mibIncReq(mibIncReq), .mibIncAddr(mibIncAddr),
    .mibIncVal(mibIncVal), .mibIncAck(mibIncAck),
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr),
    .ramWData(ramWData), .ramRData(ramRData)
  );

  always #5 hClk = ~hClk;

  always @(posedge hClk) begin
    if (ramEn) begin
      if (ramWe) ram_mem[ramAddr] <= ramWData;
      else       ramRData <= ram_mem[ramAddr];
    end
  end

  always @(posedge hClk) begin
    if (ramEn) acc_q.push_back('{cyc, ramWe, ramAddr, ramWData});
    if (mibIncAck) ack_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [15:0] v);
    longint s;
    s = longint'(a) + longint'(v);
    if (s > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return a + 32'(v);
  endfunction

  task automatic step();
    @(posedge hClk); #1;
  endtask

  task automatic host_access(input bit wr, input logic [13:0] a,
                             input logic [31:0] d,
                             output int lat, output logic [31:0] rd);
    @(posedge hClk); #1;
    regWrite = wr; regRead = !wr; rdWrAddr = a; regWrData = d;
    lat = 0;
    #1;
    while (!mibReady && lat < 20) begin
      lat++;
      @(posedge hClk); #1;
      regWrite = 0; regRead = 0;
      #1;
    end
    if (lat == 0) begin
      @(posedge hClk); #1;
    end
    regWrite = 0; regRead = 0;
    rd = mibRdData;
  endtask

  task automatic do_inc(input logic [6:0] a, input logic [15:0] v,
                        output bit ok);
    @(posedge hClk); #1;
    mibIncReq = 1; mibIncAddr = a; mibIncVal = v;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge hClk); #1;
      if (mibIncAck) begin ok = 1; break; end
    end
    mibIncReq = 0;
  endtask

  task automatic test_reset();
    hardRstHClk = 1; regWrite = 0; regRead = 0;
    rdWrAddr = 0; regWrData = 0; mibIncReq = 0;
    mibIncAddr = 0; mibIncVal = 0;
    repeat (3) step();
    tests_run++;
    if (mibReady !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 1", mibReady);
    end
    tests_run++;
    if (mibSel !== 1'b0 || mibRdData !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_rd: got sel=%b data=%h expected 0/0",
               mibSel, mibRdData);
    end
    tests_run++;
    if (mibIncAck !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ack: got %b expected 0", mibIncAck);
    end
    tests_run++;
    if ({ramEn, ramWe, ramAddr, ramWData} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ram: got en=%b we=%b a=%h d=%h expected 0",
               ramEn, ramWe, ramAddr, ramWData);
    end
    hardRstHClk = 0;
    step();
  endtask

  task automatic test_host_rw();
    int lat;
    logic [31:0] rd;
    host_access(1, 14'h0805, 32'hA5A5_0001, lat, rd);
    tests_run++;
    if (lat != 2) begin
      tests_failed++;
      $display("FAIL wr_latency: got %0d expected 2", lat);
    end
    tests_run++;
    if (ram_mem[5] !== 32'hA5A5_0001) begin
      tests_failed++;
      $display("FAIL wr_entry5: got %h expected a5a50001", ram_mem[5]);
    end
    host_access(0, 14'h0805, 32'h0, lat, rd);
    tests_run++;
    if (lat != RD_LAT) begin
      tests_failed++;
      $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT);
    end
    tests_run++;
    if (rd !== 32'hA5A5_0001 || mibSel !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_data: got %h sel=%b expected a5a50001 sel=1",
               rd, mibSel);
    end
    host_access(1, 14'h0800, 32'h1111_0000, lat, rd);
    tests_run++;
    if (mibSel !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_clears_sel: got %b expected 0", mibSel);
    end
    host_access(1, 14'h087F, 32'h7F7F_7F7F, lat, rd);
    tests_run++;
    if (ram_mem[0] !== 32'h1111_0000 || ram_mem[127] !== 32'h7F7F_7F7F) begin
      tests_failed++;
      $display("FAIL window_edges: got %h %h expected 11110000 7f7f7f7f",
               ram_mem[0], ram_mem[127]);
    end
  endtask

  task automatic test_miss();
    int lat;
    logic [31:0] rd;
    logic [13:0] addrs [4];
    logic        sel0;
    addrs[0] = 14'h07FF; addrs[1] = 14'h0880;
    addrs[2] = 14'h0000; addrs[3] = 14'h3FFF;
    host_access(0, 14'h087F, 32'h0, lat, rd);
    sel0 = mibSel;
    acc_q.delete();
    for (int i = 0; i < 4; i++) begin
      host_access(i[0], addrs[i], 32'hDEAD_0000, lat, rd);
      tests_run++;
      if (lat != 0 || mibSel !== sel0) begin
        tests_failed++;
        $display("FAIL miss_%h: got lat=%0d sel=%b expected 0/%b",
                 addrs[i], lat, mibSel, sel0);
      end
    end
    step();
    tests_run++;
    if (acc_q.size() != 0) begin
      tests_failed++;
      $display("FAIL miss_ram: got %0d accesses expected 0", acc_q.size());
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [31:0] rd;
    bit ok;
    host_access(1, 14'h0803, 32'hFFFF_FFF0, lat, rd);
    acc_q.delete(); ack_q.delete();
    do_inc(7'd3, 16'h0020, ok);
    step();
    tests_run++;
    if (!ok || ram_mem[3] !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL saturate: got ok=%0d %h expected 1 ffffffff",
               ok, ram_mem[3]);
    end
    tests_run++;
    if (acc_q.size() != 2 || ack_q.size() != 1) begin
      tests_failed++;
      $display("FAIL inc_shape: got acc=%0d ack=%0d expected 2/1",
               acc_q.size(), ack_q.size());
    end else begin
      tests_run++;
      if (acc_q[0].we || !acc_q[1].we || acc_q[1].a != 7'd3 ||
          acc_q[1].c != acc_q[0].c + 2 || ack_q[0] != acc_q[1].c) begin
        tests_failed++;
        $display("FAIL inc_timing: got rd@%0d wr@%0d ack@%0d expected wr=ack=rd+2",
                 acc_q[0].c, acc_q[1].c, ack_q[0]);
      end
    end
  endtask

  task automatic test_same_cycle();
    int lat, c0;
    logic [31:0] rd;
    bit ok;
    host_access(1, 14'h080A, 32'h0000_1234, lat, rd);
    host_access(1, 14'h080B, 32'h0000_0100, lat, rd);
    step();
    acc_q.delete();
    c0 = cyc;
    fork
      host_access(0, 14'h080A, 32'h0, lat, rd);
      do_inc(7'd11, 16'h0011, ok);
    join
    step();
    tests_run++;
    if (acc_q.size() < 3 || acc_q[0].we || acc_q[0].a != 7'd10 ||
        acc_q[0].c != c0 + 2) begin
      tests_failed++;
      $display("FAIL host_first: got n=%0d a=%h c=%0d expected a=0a c=%0d",
               acc_q.size(), acc_q.size() ? acc_q[0].a : 7'h0,
               acc_q.size() ? acc_q[0].c : 0, c0 + 2);
    end
    tests_run++;
    if (rd !== 32'h0000_1234 || lat != RD_LAT) begin
      tests_failed++;
      $display("FAIL host_first_rd: got %h lat=%0d expected 00001234 lat=%0d",
               rd, lat, RD_LAT);
    end
    tests_run++;
    if (!ok || ram_mem[11] !== 32'h0000_0111) begin
      tests_failed++;
      $display("FAIL inc_after_host: got ok=%0d %h expected 1 00000111",
               ok, ram_mem[11]);
    end
  endtask

  task automatic test_pending_write();
    int lat;
    logic [31:0] rd;
    bit ok, found;
    host_access(1, 14'h0807, 32'h0000_0050, lat, rd);
    lat = 0;
    fork
      do_inc(7'd7, 16'h0005, ok);
      begin
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
          step();
          if (ramEn && !ramWe && ramAddr == 7'd7) found = 1;
        end
        if (found) host_access(1, 14'h0807, 32'hCAFE_0007, lat, rd);
      end
    join
    step();
    tests_run++;
    if (!found || lat != 3) begin
      tests_failed++;
      $display("FAIL pending_stall: got found=%0d lat=%0d expected 1/3",
               found, lat);
    end
    tests_run++;
    if (!ok || ram_mem[7] !== 32'hCAFE_0007) begin
      tests_failed++;
      $display("FAIL pending_last: got ok=%0d %h expected 1 cafe0007",
               ok, ram_mem[7]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    bit found;
    host_access(1, 14'h0804, 32'd100, lat, rd);
    acc_q.delete(); ack_q.delete();
    step();
    mibIncReq = 1; mibIncAddr = 7'd4; mibIncVal = 16'd5;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (ramEn && !ramWe && ramAddr == 7'd4) found = 1;
    end
    step();
    hardRstHClk = 1; mibIncReq = 0;
    step();
    tests_run++;
    if (!found || ramEn !== 1'b0 || mibIncAck !== 1'b0 || mibReady !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid: got found=%0d en=%b ack=%b rdy=%b expected 1/0/0/1",
               found, ramEn, mibIncAck, mibReady);
    end
    hardRstHClk = 0;
    repeat (5) step();
    tests_run++;
    if (ack_q.size() != 0 || ram_mem[4] !== 32'd100) begin
      tests_failed++;
      $display("FAIL reset_mid_noack: got acks=%0d e4=%0d expected 0/100",
               ack_q.size(), ram_mem[4]);
    end
  endtask

`ifdef MIB_CLEAR_ON_READ_EN
  task automatic test_clear_on_read();
    int lat;
    logic [31:0] rd;
    host_access(1, 14'h0802, 32'd9, lat, rd);
    host_access(0, 14'h0802, 32'd0, lat, rd);
    tests_run++;
    if (rd !== 32'd9 || lat != 4) begin
      tests_failed++;
      $display("FAIL clr_first: got %0d lat=%0d expected 9 lat=4", rd, lat);
    end
    host_access(0, 14'h0802, 32'd0, lat, rd);
    tests_run++;
    if (rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL clr_second: got %0d expected 0", rd);
    end
  endtask
`endif

  task automatic test_random();
    int lat, op, e;
    logic [31:0] rd, d;
    logic [15:0] v;
    logic [13:0] a;
    bit ok;
    for (int i = 0; i < 128; i++) begin
      d = $urandom;
      host_access(1, 14'h0800 + 14'(i), d, lat, rd);
      model[i] = d;
    end
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      e  = $urandom_range(0, 127);
      if (op < 3) begin
        d = ($urandom_range(0, 2) == 0) ?
            32'hFFFF_FFFF - $urandom_range(0, 70000) : $urandom;
        host_access(1, 14'h0800 + 14'(e), d, lat, rd);
        model[e] = d;
        tests_run++;
        if (lat != 2) begin
          tests_failed++;
          $display("FAIL rnd_wr_lat: got %0d expected 2", lat);
        end
      end else if (op < 6) begin
        host_access(0, 14'h0800 + 14'(e), 32'h0, lat, rd);
        tests_run++;
        if (rd !== model[e] || lat != RD_LAT) begin
          tests_failed++;
          $display("FAIL rnd_rd_e%0d: got %h lat=%0d expected %h lat=%0d",
                   e, rd, lat, model[e], RD_LAT);
        end
`ifdef MIB_CLEAR_ON_READ_EN
        model[e] = 32'd0;
`endif
      end else if (op < 9) begin
        v = 16'($urandom);
        do_inc(7'(e), v, ok);
        model[e] = sat_add(model[e], v);
        tests_run++;
        if (!ok) begin
          tests_failed++;
          $display("FAIL rnd_inc_ack: got none expected ack for e%0d", e);
        end
      end else begin
        a = $urandom_range(0, 1) ? 14'($urandom_range(0, 14'h07FF)) :
                                   14'($urandom_range(14'h0880, 14'h3FFF));
        host_access($urandom_range(0, 1), a, $urandom, lat, rd);
        tests_run++;
        if (lat != 0) begin
          tests_failed++;
          $display("FAIL rnd_miss_%h: got lat=%0d expected 0", a, lat);
        end
      end
    end
    step();
    for (int i = 0; i < 128; i++) begin
      tests_run++;
      if (ram_mem[i] !== model[i]) begin
        tests_failed++;
        $display("FAIL rnd_final_e%0d: got %h expected %h",
                 i, ram_mem[i], model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_miss();
    test_saturate();
    test_same_cycle();
    test_pending_write();
    test_reset_mid();
`ifdef MIB_CLEAR_ON_READ_EN
    test_clear_on_read();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
